imem_resp: RTL and testbench
============================

IMEM_RESP -- requirements
Module: imem_resp

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, instruction memory size in 32-bit words (power of two).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h8000_0000, byte address of word 0.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous assert, active-low.
REQ-005 SHALL have port req_valid, input, 1, fetch request present.
REQ-006 SHALL have port req_ready, output, 1, request can be accepted.
REQ-007 SHALL have port req_addr, input, `CPU_WIDTH, fetch byte address (pc).
REQ-008 SHALL have port rsp_valid, output, 1, instruction response present.
REQ-009 SHALL have port rsp_ready, input, 1, consumer takes response.
REQ-010 SHALL have port rsp_inst, output, 32, fetched instruction.
REQ-011 SHALL have port rsp_err, output, 1, access fault for this response.
REQ-012 SHALL have ports ld_wen (input, 1), ld_addr (input, log2(DEPTH)), ld_data (input, 32): word-indexed memory preload/write port.

Function
REQ-013 SHALL accept a request on the cycle req_valid and req_ready are both 1 (req fire); likewise rsp fire for rsp_valid and rsp_ready.
REQ-014 SHALL read mem[(req_addr-BASE_ADDR)>>2] at req fire and push {inst, err} into a 2-entry in-order response FIFO at that clock edge.
REQ-015 SHALL present a response with rsp_valid=1 in cycle n+1 after req fire in cycle n when the FIFO was empty (latency 1).
REQ-016 SHALL keep a 2-bit occupancy counter: +1 on req fire, -1 on rsp fire, unchanged when both or neither occur.
REQ-017 SHALL drive req_ready = (occupancy < 2), registered-state only; no combinational path from rsp_ready or req_valid to req_ready.
REQ-018 SHALL sustain one request and one response per cycle when rsp_ready is held 1.
REQ-019 SHALL hold rsp_inst/rsp_err stable while rsp_valid=1 and rsp_ready=0.
REQ-020 SHALL drive rsp_valid = FIFO not empty; rsp_inst/rsp_err from FIFO head.
REQ-021 SHALL write ld_data to mem[ld_addr] at the edge when ld_wen=1.
REQ-022 SHALL return the pre-write word when ld_wen and req fire hit the same word in one cycle (read-before-write).
REQ-023 SHALL return responses strictly in request order.

Reset
REQ-024 SHALL on rst_n=0 immediately clear occupancy, FIFO pointers and counts; req_ready=1, rsp_valid=0, rsp_inst=0, rsp_err=0 while in reset.
REQ-025 SHALL discard all outstanding responses on reset mid-operation; memory contents SHALL NOT be reset.

Configuration
REQ-026 SHALL compile the access-fault check under macro IMEM_RESP_ERR_EN.
REQ-027 With IMEM_RESP_ERR_EN defined: err=1 when req_addr[1:0]!=0 or address outside [BASE_ADDR, BASE_ADDR+4*DEPTH); such responses carry rsp_inst=32'h0000_0013 (nop).
REQ-028 Without IMEM_RESP_ERR_EN: rsp_err tied 0, low address bits ignored, index wraps modulo DEPTH.

Structure
REQ-029 SHALL take CPU_WIDTH and new constants IMEM_DEPTH, IMEM_BASE_ADDR, INST_NOP from the shared rvseed_defines include.
REQ-030 SHALL instantiate one sub-module imem_resp_fifo (2-entry, 33-bit wide, valid/ready both sides).

Verification
REQ-031 Preload mem[0]=32'h0010_0093; req 32'h8000_0000, rsp_ready=1 -> next cycle rsp_valid=1, rsp_inst=32'h0010_0093, rsp_err=0.
REQ-032 Back-to-back reqs 32'h8000_0000/04/08, rsp_ready=1 -> req_ready stays 1, three responses in consecutive cycles, in order.
REQ-033 rsp_ready=0, issue reqs -> two accepted, req_ready=0 from third cycle, head data stable; raise rsp_ready -> drains in order, req_ready returns 1 cycle after first pop.
REQ-034 With IMEM_RESP_ERR_EN: req 32'h8000_0002 and 32'h8000_1000 (DEPTH=1024) -> rsp_err=1, rsp_inst=32'h0000_0013; without macro: rsp_err=0, index 0.
REQ-035 Same cycle ld_wen to word 5 with 32'hDEAD_BEEF and req 32'h8000_0014 -> old word returned; repeat req -> 32'hDEAD_BEEF.
REQ-036 Assert rst_n=0 with 2 responses pending -> rsp_valid=0, req_ready=1 immediately; after release, fresh req returns correct data.

Source files
------------

// File: rtl/imem_resp_pkg.sv
// rtl/imem_resp_pkg.sv - response record shared by imem_resp and its response FIFO
`ifndef RVSEED_DEFINES_SV
`include "rvseed_defines.sv"
`endif

package imem_resp_pkg;

    typedef struct packed {
        logic        err;
        logic [31:0] inst;
    } imem_rsp_t;

    localparam int RSP_W = $bits(imem_rsp_t);

endpackage

// File: rtl/imem_resp_fifo.sv
// rtl/imem_resp_fifo.sv - 2-entry in-order response FIFO with occupancy counter
module imem_resp_fifo
    import imem_resp_pkg::*;
#(
    parameter int WIDTH = RSP_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] s_tdata,
    input  logic             s_tvalid,
    output logic             s_tready,
    output logic [WIDTH-1:0] m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready
);

    logic [WIDTH-1:0] slot_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             push;
    logic             pop;

    // Ready depends only on the registered count, never on the consumer side.
    assign s_tready = (count_q != 2'd2);
    assign m_tvalid = (count_q != 2'd0);
    assign m_tdata  = m_tvalid ? slot_q[rd_ptr_q] : '0;

    assign push = s_tvalid && s_tready;
    assign pop  = m_tvalid && m_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            slot_q[wr_ptr_q] <= s_tdata;
        end
    end

endmodule

// File: rtl/rvseed_defines.sv
// rtl/rvseed_defines.sv - shared rvseed width and instruction memory map constants
`ifndef RVSEED_DEFINES_SV
`define RVSEED_DEFINES_SV
`define CPU_WIDTH 32
`define IMEM_DEPTH 1024
`define IMEM_BASE_ADDR 32'h8000_0000
`define INST_NOP 32'h0000_0013
`endif

// File: rtl/imem_resp.sv
// rtl/imem_resp.sv - instruction memory with latency-1 fetch responses; IMEM_RESP_ERR_EN adds access-fault checking
module imem_resp
    import imem_resp_pkg::*;
#(
    parameter int                    DEPTH     = `IMEM_DEPTH,
    parameter logic [`CPU_WIDTH-1:0] BASE_ADDR = `IMEM_BASE_ADDR
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [`CPU_WIDTH-1:0]    req_addr,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_inst,
    output logic                     rsp_err,
    input  logic                     ld_wen,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [31:0]              ld_data
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0] mem [DEPTH];
    imem_rsp_t   rd_rsp;
    imem_rsp_t   head;

    // Memory is never reset; the fetch read below sees the pre-write word.
    always_ff @(posedge clk) begin
        if (ld_wen) begin
            mem[ld_addr] <= ld_data;
        end
    end

`ifdef IMEM_RESP_ERR_EN
    logic [`CPU_WIDTH-1:0] offset;
    logic                  fault;

    // Addresses below BASE_ADDR wrap to large offsets and land in the upper-bits test.
    assign offset = req_addr - BASE_ADDR;
    assign fault  = (|offset[1:0]) || (|offset[`CPU_WIDTH-1:AW+2]);

    always_comb begin
        rd_rsp.err  = fault;
        rd_rsp.inst = fault ? `INST_NOP : mem[offset[AW+1:2]];
    end
`else
    logic [AW-1:0] word_idx;
    logic          unused_addr_bits;

    assign word_idx         = req_addr[AW+1:2] - BASE_ADDR[AW+1:2];
    assign unused_addr_bits = ^{req_addr[`CPU_WIDTH-1:AW+2], req_addr[1:0]};

    always_comb begin
        rd_rsp.err  = 1'b0;
        rd_rsp.inst = mem[word_idx];
    end
`endif

    imem_resp_fifo #(
        .WIDTH (RSP_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_tdata  (rd_rsp),
        .s_tvalid (req_valid),
        .s_tready (req_ready),
        .m_tdata  (head),
        .m_tvalid (rsp_valid),
        .m_tready (rsp_ready)
    );

    assign rsp_inst = head.inst;
    assign rsp_err  = head.err;

endmodule

// File: tb/tb_imem_resp.sv
// tb/tb_imem_resp.sv - scoreboard bench for imem_resp
module tb_imem_resp;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_inst;
    logic        rsp_err;
    logic        ld_wen = 1'b0;
    logic [9:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;

    int checks = 0;
    int errors = 0;
    int pops = 0;

    logic [32:0] exp_q [$];
    logic [31:0] model [DEPTH];
    logic        last_rsp_valid;
    logic        last_req_ready;
    logic [32:0] last_rsp;
    logic        stall_q = 1'b0;
    logic [32:0] stall_data;
    logic [32:0] mon_exp;

    imem_resp #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_inst  (rsp_inst),
        .rsp_err   (rsp_err),
        .ld_wen    (ld_wen),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data)
    );

    always #5 clk = ~clk;

    function automatic logic [32:0] expect_rsp(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
`ifdef IMEM_RESP_ERR_EN
        if (off[1:0] != 2'b00 || off >= 32'(4 * DEPTH)) begin
            return {1'b1, 32'h0000_0013};
        end
        return {1'b0, model[off >> 2]};
`else
        return {1'b0, model[(off >> 2) % DEPTH]};
`endif
    endfunction

    // One clock of stimulus; the expected response is taken from the model before any same-cycle load.
    task automatic step(input logic rv, input logic [31:0] addr, input logic rr,
                        input logic lw, input logic [9:0] la, input logic [31:0] ld);
        req_valid = rv;
        req_addr  = addr;
        rsp_ready = rr;
        ld_wen    = lw;
        ld_addr   = la;
        ld_data   = ld;
        @(negedge clk);
        last_rsp_valid = rsp_valid;
        last_req_ready = req_ready;
        last_rsp       = {rsp_err, rsp_inst};
        if (rv && req_ready) begin
            exp_q.push_back(expect_rsp(addr));
        end
        if (lw) begin
            model[la] = ld;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rr);
        step(1'b0, 32'h0, rr, 1'b0, 10'd0, 32'h0);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q && rsp_valid) begin
                checks++;
                if ({rsp_err, rsp_inst} !== stall_data) begin
                    errors++;
                    $display("FAIL stall_stable: got %h want %h", {rsp_err, rsp_inst}, stall_data);
                end
            end
            if (rsp_valid && rsp_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rsp: got %h want no response", {rsp_err, rsp_inst});
                end else begin
                    mon_exp = exp_q.pop_front();
                    pops++;
                    if ({rsp_err, rsp_inst} !== mon_exp) begin
                        errors++;
                        $display("FAIL rsp_data: got %h want %h", {rsp_err, rsp_inst}, mon_exp);
                    end
                end
            end
            stall_q    = rsp_valid && !rsp_ready;
            stall_data = {rsp_err, rsp_inst};
        end
    end

    task automatic check_reset_outputs(input string tag);
        checks++;
        if ({req_ready, rsp_valid, rsp_err, rsp_inst} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL %s: got rdy=%b vld=%b err=%b inst=%h want rdy=1 vld=0 err=0 inst=0",
                     tag, req_ready, rsp_valid, rsp_err, rsp_inst);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset_state");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic preload();
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b1, 10'(i), (i == 0) ? 32'h0010_0093 : $urandom);
        end
    endtask

    task automatic test_basic();
        step(1'b1, BASE, 1'b1, 1'b0, 10'd0, 32'h0);
        idle(1'b1);
        checks++;
        if ({last_rsp_valid, last_rsp} !== {1'b1, 1'b0, 32'h0010_0093}) begin
            errors++;
            $display("FAIL basic_latency1: got vld=%b rsp=%h want vld=1 rsp=000100093",
                     last_rsp_valid, last_rsp);
        end
    endtask

    task automatic test_back_to_back();
        int start_pops;
        start_pops = pops;
        for (int i = 0; i < 5; i++) begin
            step(i < 3, BASE + 32'(4 * i), 1'b1, 1'b0, 10'd0, 32'h0);
            if (i < 3) begin
                checks++;
                if (last_req_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_req_ready[%0d]: got %b want 1", i, last_req_ready);
                end
            end
            if (i >= 1) begin
                checks++;
                if (last_rsp_valid !== (i <= 3)) begin
                    errors++;
                    $display("FAIL b2b_rsp_valid[%0d]: got %b want %b", i, last_rsp_valid, i <= 3);
                end
            end
        end
        checks++;
        if (pops - start_pops != 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d want 3", pops - start_pops);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, BASE + 32'h20 + 32'(4 * ((i < 2) ? i : 2)), 1'b0, 1'b0, 10'd0, 32'h0);
            checks++;
            if (last_req_ready !== (i < 2)) begin
                errors++;
                $display("FAIL bp_req_ready[%0d]: got %b want %b", i, last_req_ready, i < 2);
            end
            if (i >= 1) begin
                checks++;
                if (!last_rsp_valid || exp_q.size() == 0 || last_rsp !== exp_q[0]) begin
                    errors++;
                    $display("FAIL bp_head[%0d]: got vld=%b rsp=%h want vld=1 head of scoreboard",
                             i, last_rsp_valid, last_rsp);
                end
            end
        end
        idle(1'b1);
        checks++;
        if (last_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready_at_pop: got %b want 0", last_req_ready);
        end
        idle(1'b1);
        checks++;
        if ({last_req_ready, last_rsp_valid} !== 2'b11) begin
            errors++;
            $display("FAIL bp_ready_after_pop: got rdy=%b vld=%b want rdy=1 vld=1",
                     last_req_ready, last_rsp_valid);
        end
        idle(1'b1);
        checks++;
        if ({last_req_ready, last_rsp_valid} !== 2'b10) begin
            errors++;
            $display("FAIL bp_drained: got rdy=%b vld=%b want rdy=1 vld=0",
                     last_req_ready, last_rsp_valid);
        end
    endtask

    task automatic test_err();
        logic [32:0] want;
`ifdef IMEM_RESP_ERR_EN
        want = {1'b1, 32'h0000_0013};
`else
        want = {1'b0, 32'h0010_0093};
`endif
        step(1'b1, BASE + 32'h2, 1'b1, 1'b0, 10'd0, 32'h0);
        step(1'b1, BASE + 32'h1000, 1'b1, 1'b0, 10'd0, 32'h0);
        checks++;
        if (last_rsp !== want) begin
            errors++;
            $display("FAIL err_misaligned: got %h want %h", last_rsp, want);
        end
        idle(1'b1);
        checks++;
        if (last_rsp !== want) begin
            errors++;
            $display("FAIL err_out_of_range: got %h want %h", last_rsp, want);
        end
    endtask

    task automatic test_read_before_write();
        logic [31:0] old_word;
        old_word = model[5];
        step(1'b1, BASE + 32'h14, 1'b1, 1'b1, 10'd5, 32'hDEAD_BEEF);
        step(1'b1, BASE + 32'h14, 1'b1, 1'b0, 10'd0, 32'h0);
        checks++;
        if (last_rsp !== {1'b0, old_word}) begin
            errors++;
            $display("FAIL rbw_old: got %h want %h", last_rsp, {1'b0, old_word});
        end
        idle(1'b1);
        checks++;
        if (last_rsp !== {1'b0, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL rbw_new: got %h want 0deadbeef", last_rsp);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, BASE + 32'h30, 1'b0, 1'b0, 10'd0, 32'h0);
        step(1'b1, BASE + 32'h34, 1'b0, 1'b0, 10'd0, 32'h0);
        req_valid = 1'b0;
        rst_n     = 1'b0;
        #1 check_reset_outputs("reset_mid");
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1'b1, BASE + 32'h38, 1'b1, 1'b0, 10'd0, 32'h0);
        idle(1'b1);
        checks++;
        if ({last_rsp_valid, last_rsp} !== {1'b1, 1'b0, model[14]}) begin
            errors++;
            $display("FAIL reset_fresh_req: got vld=%b rsp=%h want vld=1 rsp=%h",
                     last_rsp_valid, last_rsp, {1'b0, model[14]});
        end
        idle(1'b1);
    endtask

    initial begin
        test_reset();
        preload();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_err();
        test_read_before_write();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %0d pending want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
